sram_controller: RTL and testbench

Sequencer between the ARM core's memory stage and the 16-bit external SRAM (18-bit address, active-low write enable). It turns one 32-bit load or store into two timed 16-bit SRAM accesses, low half then high half. It holds `ready` low so the pipeline freezes until the access completes.

---
 rtl/sram_pkg.sv | 10 +
 rtl/sram_wait_timer.sv | 26 ++
 rtl/sram_controller.sv | 117 +++++++++++
 tb/tb_sram_controller.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared types and constants for the 16-bit external SRAM sequencer.
package sram_pkg;

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} sram_state_e;

  localparam int unsigned DATA_BASE_DEFAULT = 1024;
  localparam int unsigned SRAM_AW = 18;
  localparam int unsigned SRAM_DW = 16;

endpackage

// File: rtl/sram_wait_timer.sv
// Per-phase wait counter; done flags the last cycle of a WAIT_CYCLES-long SRAM access.
module sram_wait_timer #(
  parameter int unsigned WAIT_CYCLES = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic done
);

  logic [3:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 4'd0;
    end else if (clear) begin
      count_q <= 4'd0;
    end else if (enable) begin
      count_q <= count_q + 4'd1;
    end
  end

  assign done = (count_q == 4'(WAIT_CYCLES - 1));

endmodule

// File: rtl/sram_controller.sv
// Splits one 32-bit load/store into two timed 16-bit SRAM accesses (low half, then high half)
// and holds ready low until the pair completes.
module sram_controller
  import sram_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 5,
  parameter int unsigned DATA_BASE   = DATA_BASE_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic [31:0]        address,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic               ready,
  inout  wire  [SRAM_DW-1:0] SRAM_DQ,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic               SRAM_WE_N
);

  sram_state_e        state_q, state_d;
  logic               is_wr_q, is_wr_d;
  logic [SRAM_AW-2:0] word_q, word_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [SRAM_AW-1:0] addr_q, addr_d;
  logic               we_n_q, we_n_d;
  logic               timer_clear, timer_en, timer_done;
  logic [SRAM_AW-2:0] word_in;

  // Out-of-range addresses simply wrap; no range check.
  assign word_in = (SRAM_AW-1)'((address - DATA_BASE) >> 2);

  sram_wait_timer #(
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_wait_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (timer_clear),
    .enable (timer_en),
    .done   (timer_done)
  );

  always_comb begin
    state_d     = state_q;
    is_wr_d     = is_wr_q;
    word_d      = word_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    addr_d      = addr_q;
    we_n_d      = we_n_q;
    timer_clear = 1'b1;
    timer_en    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (wr_en | rd_en) begin
          state_d = LO;
          is_wr_d = wr_en;
          word_d  = word_in;
          wdata_d = wdata;
          addr_d  = {word_in, 1'b0};
          we_n_d  = ~wr_en;
        end
      end
      LO: begin
        timer_en    = 1'b1;
        timer_clear = timer_done;
        if (timer_done) begin
          state_d = HI;
          addr_d  = {word_q, 1'b1};
          if (!is_wr_q) rdata_d[15:0] = SRAM_DQ;
        end
      end
      HI: begin
        timer_en    = 1'b1;
        timer_clear = timer_done;
        if (timer_done) begin
          state_d = DONE;
          we_n_d  = 1'b1;
          if (!is_wr_q) rdata_d[31:16] = SRAM_DQ;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      is_wr_q <= 1'b0;
      word_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      addr_q  <= '0;
      we_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      is_wr_q <= is_wr_d;
      word_q  <= word_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      we_n_q  <= we_n_d;
    end
  end

  assign rdata     = rdata_q;
  assign SRAM_ADDR = addr_q;
  assign SRAM_WE_N = we_n_q;
  assign ready     = ~(wr_en | rd_en) | (state_q == DONE);

  assign SRAM_DQ = (is_wr_q && (state_q == LO || state_q == HI)) ?
                   ((state_q == HI) ? wdata_q[31:16] : wdata_q[15:0]) : {SRAM_DW{1'bz}};

endmodule

// File: tb/tb_sram_controller.sv
// Randomized self-checking bench for sram_controller against a word-level memory model.
module tb_sram_controller;

  localparam int unsigned W     = 5;
  localparam int unsigned BASE  = 1024;
  localparam int unsigned MEM_N = 1 << 18;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] wdata = '0;
  wire  [31:0] rdata;
  wire         ready;
  wire  [15:0] sram_dq;
  wire  [17:0] sram_addr;
  wire         sram_we_n;

  logic [15:0] mem     [0:MEM_N-1];
  logic [15:0] ref_mem [0:MEM_N-1];
  logic [31:0] exp_rdata = '0;
  int          checks = 0;
  int          errors = 0;

  sram_controller #(
    .WAIT_CYCLES (W),
    .DATA_BASE   (BASE)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .address   (address),
    .wdata     (wdata),
    .rdata     (rdata),
    .ready     (ready),
    .SRAM_DQ   (sram_dq),
    .SRAM_ADDR (sram_addr),
    .SRAM_WE_N (sram_we_n)
  );

  always #5 clk = ~clk;

  // Asynchronous SRAM with output enable tied active: drives DQ whenever not writing.
  assign sram_dq = sram_we_n ? mem[sram_addr] : 16'hzzzz;
  always @(posedge clk) if (!sram_we_n) mem[sram_addr] <= sram_dq;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [16:0] word_of(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return 17'((off / 4) % (1 << 17));
  endfunction

  // One full access starting from an IDLE cycle; returns with the DUT in its DONE cycle.
  task automatic do_access(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] d,
                           input bit scramble, input bit hold);
    int          low_cnt;
    bit          seen;
    bit          hi;
    logic [16:0] w;
    logic [17:0] ea;
    w = word_of(a);
    @(posedge clk); #1;
    wr_en = wr; rd_en = rd; address = a; wdata = d;
    #1;
    check_eq("ready_first_cycle", {31'd0, ready}, 32'd0);
    check_eq("we_n_idle", {31'd0, sram_we_n}, 32'd1);
    low_cnt = 1;
    seen = 0;
    for (int k = 1; k <= 4 * W + 8 && !seen; k++) begin
      @(posedge clk); #1;
      if (ready) begin
        seen = 1;
      end else begin
        low_cnt++;
        if (k <= 2 * W) begin
          hi = (k > W);
          ea = {w, hi};
          check_eq("sram_addr", {14'd0, sram_addr}, {14'd0, ea});
          check_eq("sram_we_n", {31'd0, sram_we_n}, {31'd0, ~wr});
          if (wr) check_eq("dq_write", {16'd0, sram_dq}, {16'd0, hi ? d[31:16] : d[15:0]});
          else    check_eq("dq_read", {16'd0, sram_dq}, {16'd0, ref_mem[ea]});
        end
        if (scramble && k == 3) begin
          address = $urandom;
          wdata   = $urandom;
        end
      end
    end
    check_eq("ready_low_cycles", low_cnt, 2 * W + 1);
    if (wr) begin
      ref_mem[{w, 1'b0}] = d[15:0];
      ref_mem[{w, 1'b1}] = d[31:16];
      check_eq("mem_lo", {16'd0, mem[{w, 1'b0}]}, {16'd0, ref_mem[{w, 1'b0}]});
      check_eq("mem_hi", {16'd0, mem[{w, 1'b1}]}, {16'd0, ref_mem[{w, 1'b1}]});
    end else begin
      exp_rdata = {ref_mem[{w, 1'b1}], ref_mem[{w, 1'b0}]};
    end
    check_eq("rdata", rdata, exp_rdata);
    check_eq("we_n_done", {31'd0, sram_we_n}, 32'd1);
    if (!hold) begin
      wr_en = 0;
      rd_en = 0;
    end
  endtask

  initial begin
    logic [16:0] aw;
    for (int i = 0; i < MEM_N; i++) begin
      mem[i]     = 16'(i * 7 + 3);
      ref_mem[i] = 16'(i * 7 + 3);
    end

    #2 rst_n = 0;
    #3;
    check_eq("rst_ready", {31'd0, ready}, 32'd1);
    check_eq("rst_we_n", {31'd0, sram_we_n}, 32'd1);
    check_eq("rst_addr", {14'd0, sram_addr}, 32'd0);
    check_eq("rst_rdata", rdata, 32'd0);
    @(negedge clk) rst_n = 1;

    do_access(1, 0, 32'd1024, 32'hDEADBEEF, 0, 0);
    check_eq("tp_store_lo", {16'd0, mem[0]}, 32'h0000BEEF);
    check_eq("tp_store_hi", {16'd0, mem[1]}, 32'h0000DEAD);
    do_access(0, 1, 32'd1024, 32'h0, 0, 0);
    check_eq("tp_load", rdata, 32'hDEADBEEF);
    do_access(1, 0, 32'd1028, 32'h12345678, 1, 0);
    check_eq("tp_scr_lo", {16'd0, mem[2]}, 32'h00005678);
    check_eq("tp_scr_hi", {16'd0, mem[3]}, 32'h00001234);
    do_access(1, 1, 32'd1032, 32'hCAFEF00D, 0, 0);
    check_eq("tp_both_rdata", rdata, 32'hDEADBEEF);
    check_eq("tp_both_mem", {16'd0, mem[5]}, 32'h0000CAFE);

    // Two loads held with no gap between them.
    do_access(0, 1, 32'd1028, 32'h0, 0, 1);
    check_eq("b2b_first", rdata, 32'h12345678);
    do_access(0, 1, 32'd1032, 32'h0, 0, 0);
    check_eq("b2b_second", rdata, 32'hCAFEF00D);

    // Store aborted by reset in its third HI cycle.
    @(posedge clk); #1;
    wr_en = 1; address = 32'd1040; wdata = 32'hA5A55A5A;
    repeat (W + 3) @(posedge clk);
    #2 rst_n = 0;
    #1;
    check_eq("abort_we_n", {31'd0, sram_we_n}, 32'd1);
    check_eq("abort_addr", {14'd0, sram_addr}, 32'd0);
    check_eq("abort_dq", {16'd0, sram_dq}, {16'd0, mem[0]});
    check_eq("abort_ready_req", {31'd0, ready}, 32'd0);
    check_eq("abort_rdata", rdata, 32'd0);
    wr_en = 0;
    #1;
    check_eq("abort_ready_idle", {31'd0, ready}, 32'd1);
    aw = word_of(32'd1040);
    ref_mem[{aw, 1'b0}] = 16'h5A5A;
    ref_mem[{aw, 1'b1}] = 16'hA5A5;
    exp_rdata = 32'd0;
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    check_eq("post_reset_ready", {31'd0, ready}, 32'd1);
    do_access(0, 1, 32'd1040, 32'h0, 0, 0);

    for (int n = 0; n < 24; n++) begin
      logic [31:0] a;
      int op;
      op = int'($urandom_range(0, 2));
      if ($urandom_range(0, 4) == 0) a = $urandom;
      else a = BASE + 4 * $urandom_range(0, 15) + $urandom_range(0, 3);
      do_access(op != 1, op != 0, a, $urandom, n[0], n[2] & n[1]);
    end
    wr_en = 0;
    rd_en = 0;
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
